btn_counter_ctrl: RTL and testbench

//   Front-panel controller for the 4-bit press counter. Debounces three raw push buttons (up, down, clear)

---
 rtl/btn_counter_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_btn_counter_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/btn_counter_ctrl.sv
// Front-panel press counter: three debounced buttons (up, down, clear) with
// auto-repeat on up/down, command arbitration and a wrapping count register.
// Each button gets its own btn_chan; the top owns the shared sample tick and
// the counter.

// One button channel: synchroniser, sample shift register, hysteretic
// debounced level and the press/hold/repeat FSM. raw_evt is combinational
// and only ever high in a tick cycle; the top registers it.
module btn_chan #(
    parameter int STABLE_N    = 5,
    parameter int REPEAT_DLY  = 50,
    parameter int REPEAT_RATE = 10,
    parameter bit HAS_RPT     = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    input  logic tick,
    output logic raw_evt
);
    localparam int HT_MAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
    localparam int HT_W   = $clog2(HT_MAX + 1);

    typedef enum logic [1:0] {IDLE, HELD, REPEAT} state_t;

    logic [1:0]          sync_q;
    logic [STABLE_N-1:0] sh_q, sh_nxt;
    logic                lvl_q, lvl_nxt, rise, fall;
    state_t              state_q, state_d;
    logic [HT_W-1:0]     hold_q, hold_d, hold_inc;

    assign sh_nxt   = {sh_q[STABLE_N-2:0], sync_q[1]};
    assign rise     = ~lvl_q & lvl_nxt;
    assign fall     = lvl_q & ~lvl_nxt;
    assign hold_inc = hold_q + 1'b1;

    // Level only moves once a full window of samples agrees (hysteresis).
    always_comb begin
        lvl_nxt = lvl_q;
        if (tick) begin
            if (&sh_nxt)       lvl_nxt = 1'b1;
            else if (~|sh_nxt) lvl_nxt = 1'b0;
        end
    end

    // Synchroniser, sample window and debounced level registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            sh_q   <= '0;
            lvl_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], btn};
            if (tick) sh_q <= sh_nxt;
            lvl_q  <= lvl_nxt;
        end
    end

    // FSM state and hold timer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    // Press/hold/repeat decisions; a release always wins over a repeat expiry.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        raw_evt = 1'b0;
        case (state_q)
            IDLE: begin
                if (rise) begin
                    raw_evt = 1'b1;
                    state_d = HELD;
                    hold_d  = '0;
                end
            end
            HELD: begin
                if (fall) begin
                    state_d = IDLE;
                    hold_d  = '0;
                end else if (tick && HAS_RPT) begin
                    if (hold_inc == HT_W'(REPEAT_DLY)) begin
                        raw_evt = 1'b1;
                        state_d = REPEAT;
                        hold_d  = '0;
                    end else begin
                        hold_d = hold_inc;
                    end
                end
            end
            REPEAT: begin
                if (fall) begin
                    state_d = IDLE;
                    hold_d  = '0;
                end else if (tick) begin
                    if (hold_inc == HT_W'(REPEAT_RATE)) begin
                        raw_evt = 1'b1;
                        hold_d  = '0;
                    end else begin
                        hold_d = hold_inc;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                hold_d  = '0;
            end
        endcase
    end
endmodule

module btn_counter_ctrl #(
    parameter int CNT_W       = 4,
    parameter int TICK_DIV    = 65536,
    parameter int STABLE_N    = 5,
    parameter int REPEAT_DLY  = 50,
    parameter int REPEAT_RATE = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn_up,
    input  logic             btn_dn,
    input  logic             btn_clr,
    output logic [CNT_W-1:0] cnt,
    output logic             up_evt,
    output logic             dn_evt,
    output logic             clr_evt,
    output logic             wrap
);
    localparam int TW = $clog2(TICK_DIV);

    logic [TW-1:0] tick_cnt;
    logic          tick;
    logic [2:0]    btn_raw, raw_evt;
    logic          up_d, dn_d, clr_d;

    assign tick    = (tick_cnt == TW'(TICK_DIV - 1));
    assign btn_raw = {btn_clr, btn_dn, btn_up};

    // Shared sample prescaler.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    tick_cnt <= '0;
        else if (tick) tick_cnt <= '0;
        else           tick_cnt <= tick_cnt + 1'b1;
    end

    // Lanes 0/1 (up/down) auto-repeat; lane 2 (clear) fires once per press.
    for (genvar i = 0; i < 3; i++) begin : g_chan
        btn_chan #(
            .STABLE_N   (STABLE_N),
            .REPEAT_DLY (REPEAT_DLY),
            .REPEAT_RATE(REPEAT_RATE),
            .HAS_RPT    (i < 2)
        ) u_chan (
            .clk    (clk),
            .rst_n  (rst_n),
            .btn    (btn_raw[i]),
            .tick   (tick),
            .raw_evt(raw_evt[i])
        );
    end

    // Clear beats everything; conflicting up+down cancel each other.
    always_comb begin
        clr_d = raw_evt[2];
        up_d  = raw_evt[0] & ~raw_evt[1] & ~raw_evt[2];
        dn_d  = raw_evt[1] & ~raw_evt[0] & ~raw_evt[2];
    end

    // Event pulses and the count move on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            up_evt  <= 1'b0;
            dn_evt  <= 1'b0;
            clr_evt <= 1'b0;
            wrap    <= 1'b0;
        end else begin
            up_evt  <= up_d;
            dn_evt  <= dn_d;
            clr_evt <= clr_d;
            wrap    <= (up_d && (cnt == '1)) || (dn_d && (cnt == '0));
            if (clr_d)     cnt <= '0;
            else if (up_d) cnt <= cnt + 1'b1;
            else if (dn_d) cnt <= cnt - 1'b1;
        end
    end
endmodule

// File: tb/tb_btn_counter_ctrl.sv
// Scoreboard bench for btn_counter_ctrl. A reference model samples the raw
// buttons on the tick schedule, debounces by run length, counts ticks held
// to place repeats, and queues the expected pulse; a monitor pops on pulses.
module tb_btn_counter_ctrl;
    localparam int CW = 4, TDIV = 4, SN = 3, DLY = 4, RATE = 2;

    typedef struct packed {
        logic       up, dn, clr, wrap;
        logic [3:0] cnt;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       bu = 1'b0, bd = 1'b0, bc = 1'b0;
    logic [3:0] cnt;
    logic       up_evt, dn_evt, clr_evt, wrap;

    int   checks = 0;
    int   errors = 0;
    exp_t q[$];

    btn_counter_ctrl #(
        .CNT_W(CW), .TICK_DIV(TDIV), .STABLE_N(SN),
        .REPEAT_DLY(DLY), .REPEAT_RATE(RATE)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .btn_up(bu), .btn_dn(bd), .btn_clr(bc),
        .cnt(cnt), .up_evt(up_evt), .dn_evt(dn_evt),
        .clr_evt(clr_evt), .wrap(wrap)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int         m_e;
    logic [2:0] m_d1, m_d2, m_last, m_lvl, samp, fire;
    int         m_run[3];
    int         m_held[3];
    logic [3:0] m_cnt;

    function automatic exp_t mk(input logic u, d, c, w, input logic [3:0] v);
        exp_t x;
        x = {u, d, c, w, v};
        return x;
    endfunction

    task automatic m_reset();
        m_e = 0; m_d1 = '0; m_d2 = '0; m_last = '0; m_lvl = '0; m_cnt = '0;
        for (int b = 0; b < 3; b++) begin m_run[b] = SN; m_held[b] = 0; end
        q.delete();
    endtask

    task automatic m_step();
        logic w;
        m_e++;
        samp = m_d2; m_d2 = m_d1; m_d1 = {bc, bd, bu};
        fire = '0;
        if (m_e % TDIV == 0) begin
            for (int b = 0; b < 3; b++) begin
                if (samp[b] == m_last[b]) m_run[b]++; else m_run[b] = 1;
                m_last[b] = samp[b];
                if (!m_lvl[b]) begin
                    if (samp[b] && m_run[b] >= SN) begin
                        m_lvl[b] = 1'b1; m_held[b] = 0; fire[b] = 1'b1;
                    end
                end else if (!samp[b] && m_run[b] >= SN) begin
                    m_lvl[b] = 1'b0;
                end else begin
                    m_held[b]++;
                    if (b < 2 && m_held[b] >= DLY && (m_held[b] - DLY) % RATE == 0)
                        fire[b] = 1'b1;
                end
            end
        end
        if (fire[2]) begin
            m_cnt = '0;
            q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, m_cnt));
        end else if (fire[0] && !fire[1]) begin
            w = (m_cnt == 4'd15);
            m_cnt = m_cnt + 4'd1;
            q.push_back(mk(1'b1, 1'b0, 1'b0, w, m_cnt));
        end else if (fire[1] && !fire[0]) begin
            w = (m_cnt == 4'd0);
            m_cnt = m_cnt - 4'd1;
            q.push_back(mk(1'b0, 1'b1, 1'b0, w, m_cnt));
        end
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) m_reset();
            else        m_step();
        end
    end

    // ---------------- monitor ----------------
    initial begin
        exp_t act, exp;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                checks++;
                if (cnt !== m_cnt) begin
                    errors++;
                    $display("FAIL cnt_track act=%0d exp=%0d t=%0t", cnt, m_cnt, $time);
                end
                if (up_evt || dn_evt || clr_evt || wrap) begin
                    act = {up_evt, dn_evt, clr_evt, wrap, cnt};
                    checks++;
                    if (q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_evt act=%h exp=none t=%0t", act, $time);
                    end else begin
                        exp = q.pop_front();
                        if (act !== exp) begin
                            errors++;
                            $display("FAIL evt act(u,d,c,w,cnt)=%b exp=%b t=%0t", act, exp, $time);
                        end
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic [2:0] b, input int n);
        {bc, bd, bu} = b;
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic press(input logic [2:0] b);
        drive(b, 16);
        drive(3'b000, 24);
    endtask

    task automatic chk_idle(input string nm);
        checks++;
        if ({cnt, up_evt, dn_evt, clr_evt, wrap} !== 8'h00) begin
            errors++;
            $display("FAIL %s act=%h exp=00", nm, {cnt, up_evt, dn_evt, clr_evt, wrap});
        end
    endtask

    task automatic goto_cnt(input logic [3:0] v);
        int g;
        g = 0;
        while (m_cnt != v && g < 20) begin press(3'b001); g++; end
        checks++;
        if (m_cnt != v) begin
            errors++;
            $display("FAIL goto_cnt act=%0d exp=%0d", m_cnt, v);
        end
    endtask

    initial begin
        int g;
        repeat (2) @(negedge clk);
        chk_idle("reset_state");
        #1 rst_n = 1'b1;

        // 1: clean press held 20 cycles
        drive(3'b001, 20);
        drive(3'b000, 30);
        // 2: bouncy up for 40 cycles, then steady
        for (int i = 0; i < 8; i++) drive({2'b00, i[0] ? 1'b0 : 1'b1}, 5);
        drive(3'b001, 30);
        drive(3'b000, 24);
        // 3: long hold with auto-repeat
        drive(3'b001, 60);
        drive(3'b000, 24);
        // 4: wrap both ways
        goto_cnt(4'd15);
        press(3'b001);
        press(3'b010);
        // 5: conflicting presses
        press(3'b011);
        goto_cnt(4'd7);
        press(3'b101);
        // 6: reset mid-repeat at cnt=9
        goto_cnt(4'd7);
        bu = 1'b1;
        g = 0;
        while (m_cnt != 4'd9 && g < 400) begin @(negedge clk); g++; end
        checks++;
        if (m_cnt != 4'd9) begin
            errors++;
            $display("FAIL repeat_timeout act=%0d exp=9", m_cnt);
        end
        #2 rst_n = 1'b0;
        #1 chk_idle("reset_mid_repeat");
        repeat (3) @(negedge clk);
        #1 chk_idle("reset_held");
        rst_n = 1'b1;
        drive(3'b001, 40);
        drive(3'b000, 24);

        // random phase: mixed presses, holds and short bounces
        for (int i = 0; i < 150; i++) begin
            logic [2:0] b;
            b = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) b[2] = 1'b0;
            drive(b, $urandom_range(1, 40));
        end
        drive(3'b000, 40);

        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL missing_evts act=%0d exp=0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
